// File: rtl/vga_pixel_out.sv
// VGA timing generator and output stage: pixel counters, start-of-frame pulse,
// pipeline-aligned sync/blank, and RGB332 to 8-8-8 colour expansion.
module vga_pixel_out #(
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
  // Idle delay-line entry: {hsync, vsync, visible}
  localparam logic [2:0]  DLY_IDLE = 3'b110;

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             sof_q, sof_d;
  logic             strobe_s, vis_s, hs_s, vs_s;
  logic [2:0]       dly_q [PIPE_DELAY];
  logic [2:0]       tap_s;
  logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             hsync_q, vsync_q, blank_q;

  // Divider, pixel/line counters and the start-of-frame pulse
  always_comb begin
    strobe_s = (div_q == DIV_LAST);
    div_d    = div_q;
    x_d      = x_q;
    y_d      = y_q;
    sof_d    = 1'b0;
    if (strobe_s) begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = 11'd0;
        if (y_q == V_LAST) begin
          y_d   = 11'd0;
          sof_d = 1'b1;
        end else begin
          y_d = y_q + 11'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_q <= '0;
      x_q   <= 11'd0;
      y_q   <= 11'd0;
      sof_q <= 1'b0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      sof_q <= sof_d;
    end
  end

  always_comb begin
    vis_s = (x_q < H_VIS) && (y_q < V_VIS);
    hs_s  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    vs_s  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    tap_s = dly_q[PIPE_DELAY-1];
  end

  // Delay line advances every clk so it tracks the drawing pipeline, not the strobe
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= DLY_IDLE;
    end else begin
      dly_q[0] <= {~hs_s, ~vs_s, vis_s};
      for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_comb begin
    red_d   = 8'd0;
    green_d = 8'd0;
    blue_d  = 8'd0;
    if (tap_s[0]) begin
      red_d   = expand3(RGBIn[7:5]);
      green_d = expand3(RGBIn[4:2]);
      blue_d  = expand2(RGBIn[1:0]);
    end else begin
      red_d   = 8'd0;
      green_d = 8'd0;
      blue_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      red_q   <= 8'd0;
      green_q <= 8'd0;
      blue_q  <= 8'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= tap_s[2];
      vsync_q <= tap_s[1];
      blank_q <= tap_s[0];
    end
  end

  assign pixelX       = x_q;
  assign pixelY       = y_q;
  assign startOfFrame = sof_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blankN       = blank_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Scoreboard bench for vga_pixel_out on a shrunken raster so whole frames fit in a short run.
module tb_vga_pixel_out;

  localparam int CLK_DIV = 2;
  localparam int PD      = 3;
  localparam int HV = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VV = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        bl;
  } exp_t;

  logic        clk;
  logic        resetN;
  logic [7:0]  RGBIn;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, hsync, vsync, blankN;
  logic [7:0]  red, green, blue;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   k        = 0;
  exp_t exp_q[$];

  vga_pixel_out #(
    .CLK_DIV(CLK_DIV), .PIPE_DELAY(PD),
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .blankN(blankN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, k, $time);
  endtask

  // Outputs after k clk edges since reset release, with rgb presented before edge k.
  function automatic exp_t model(input int kk, input logic [7:0] rgb);
    exp_t e;
    int p, kd, pd, dx, dy;
    logic [2:0] rc, gc;
    logic [1:0] bc;
    p     = kk / CLK_DIV;
    e.x   = 11'(p % HT);
    e.y   = 11'((p / HT) % VT);
    e.sof = (kk > 0) && (kk % CLK_DIV == 0) && (p % (HT * VT) == 0);
    kd    = kk - PD - 1;
    e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
    e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
    if (kd >= 0) begin
      pd   = kd / CLK_DIV;
      dx   = pd % HT;
      dy   = (pd / HT) % VT;
      e.bl = (dx < HV) && (dy < VV);
      e.hs = !((dx >= HV + HFP) && (dx < HV + HFP + HS));
      e.vs = !((dy >= VV + VFP) && (dy < VV + VFP + VS));
      if (e.bl) begin
        rc  = rgb[7:5];
        gc  = rgb[4:2];
        bc  = rgb[1:0];
        e.r = {rc, rc, rc[2:1]};
        e.g = {gc, gc, gc[2:1]};
        e.b = {bc, bc, bc, bc};
      end
    end
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    cmp({tag, "_pixelX"}, 32'(pixelX), 32'd0);
    cmp({tag, "_pixelY"}, 32'(pixelY), 32'd0);
    cmp({tag, "_sof"},    32'(startOfFrame), 32'd0);
    cmp({tag, "_red"},    32'(red),   32'd0);
    cmp({tag, "_green"},  32'(green), 32'd0);
    cmp({tag, "_blue"},   32'(blue),  32'd0);
    cmp({tag, "_hsync"},  32'(hsync), 32'd1);
    cmp({tag, "_vsync"},  32'(vsync), 32'd1);
    cmp({tag, "_blankN"}, 32'(blankN), 32'd0);
  endtask

  task automatic drive(input int n, input bit hold_ff);
    logic [7:0] dir [5];
    logic [7:0] v;
    dir = '{8'hE0, 8'h1C, 8'h03, 8'h49, 8'hFF};
    for (int i = 0; i < n; i++) begin
      if (hold_ff) v = 8'hFF;
      else if ($urandom_range(0, 1) == 1) v = dir[$urandom_range(0, 4)];
      else v = 8'($urandom);
      RGBIn = v;
      k++;
      exp_q.push_back(model(k, v));
      @(negedge clk);
    end
  endtask

  // Monitor: every clk after reset release one expected record is due
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pixelX", 32'(pixelX), 32'(e.x));
        cmp("pixelY", 32'(pixelY), 32'(e.y));
        cmp("startOfFrame", 32'(startOfFrame), 32'(e.sof));
        cmp("red",    32'(red),    32'(e.r));
        cmp("green",  32'(green),  32'(e.g));
        cmp("blue",   32'(blue),   32'(e.b));
        cmp("hsync",  32'(hsync),  32'(e.hs));
        cmp("vsync",  32'(vsync),  32'(e.vs));
        cmp("blankN", 32'(blankN), 32'(e.bl));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    RGBIn  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    resetN = 1'b1;
    k = 0;
    // Two full frames of mixed colours, then stop at pixel (10,5)
    drive(2 * FRAME_CLKS + (5 * HT + 10) * CLK_DIV, 1'b0);
    resetN = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clk);
    check_reset_values("midreset_hold");
    resetN = 1'b1;
    k = 0;
    drive(FRAME_CLKS + FRAME_CLKS / 2, 1'b1);
    drive(40, 1'b0);
    repeat (2) @(negedge clk);
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
